// File: rtl/wash_ctrl_pkg.sv
// rtl/wash_ctrl_pkg.sv - shared types and helpers for the washing-machine sequencer
// Purpose: state encoding, wash phase encoding and the rinse-index width helper.
// Ports: none (package).
package wash_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FILL      = 4'd1,
    ST_DETERGENT = 4'd2,
    ST_WASH      = 4'd3,
    ST_DRAIN     = 4'd4,
    ST_SPIN      = 4'd5,
    ST_DONE      = 4'd6,
    ST_FAULT     = 4'd7
  } state_e;

  typedef enum logic {
    PH_SOAP  = 1'b0,
    PH_RINSE = 1'b1
  } phase_e;

  // Width needed to hold 0..rinse_cnt, never narrower than one bit.
  function automatic int ri_width(input int rinse_cnt);
    int w;
    w = $clog2(rinse_cnt + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/wash_phase_timer.sv
// rtl/wash_phase_timer.sv - loadable down-counter timing the WASH/rinse/SPIN phases
// Purpose: counts a phase down to zero; load wins over hold; saturates at zero.
// Ports:
//   i_clk, i_reset  clock, asynchronous active-low reset
//   i_load          load i_load_val this cycle
//   i_load_val      value loaded (phase length minus one)
//   i_hold          freeze the count (pause or untimed state)
//   o_zero          count is zero
module wash_phase_timer #(
  parameter int TMR_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_load_val,
  input  logic             i_hold,
  output logic             o_zero
);

  logic [TMR_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (!i_hold && r_cnt != '0) begin
      r_cnt <= r_cnt - TMR_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/wash_ctrl_multi_rinse.sv
// rtl/wash_ctrl_multi_rinse.sv - washing-machine sequencer with multiple rinse passes
// Purpose: fill, detergent, wash, RINSE_CNT fill/rinse/drain passes, spin, done;
//   pause in WASH/SPIN, fill/drain watchdogs and a door-open fault state.
// Ports:
//   i_clk, i_reset                         clock, asynchronous active-low reset
//   i_start, i_pause, i_door_close         front panel / door sensor
//   i_filled, i_detergent_added, i_drained level and dispenser sensors
//   o_door_lock, o_motor_on, o_fill_valve_on, o_drain_valve_on,
//   o_detergent_req                        actuator drives
//   o_done, o_fault                        status
//   o_state, o_rinse_idx                   debug: state encoding, rinses completed
module wash_ctrl_multi_rinse
  import wash_ctrl_pkg::*;
#(
  parameter  int RINSE_CNT   = 2,
  parameter  int TMR_W       = 16,
  parameter  int WASH_TICKS  = 1000,
  parameter  int RINSE_TICKS = 500,
  parameter  int SPIN_TICKS  = 800,
  parameter  int FILL_LIMIT  = 2000,
  parameter  int DRAIN_LIMIT = 2000,
  localparam int RI_W        = ri_width(RINSE_CNT)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic            i_pause,
  input  logic            i_door_close,
  input  logic            i_filled,
  input  logic            i_detergent_added,
  input  logic            i_drained,
  output logic            o_door_lock,
  output logic            o_motor_on,
  output logic            o_fill_valve_on,
  output logic            o_drain_valve_on,
  output logic            o_detergent_req,
  output logic            o_done,
  output logic            o_fault,
  output logic [3:0]      o_state,
  output logic [RI_W-1:0] o_rinse_idx
);

  localparam longint CNT_SPAN = longint'(1) << TMR_W;

  if (WASH_TICKS < 1 || longint'(WASH_TICKS) >= CNT_SPAN ||
      RINSE_TICKS < 1 || longint'(RINSE_TICKS) >= CNT_SPAN ||
      SPIN_TICKS < 1 || longint'(SPIN_TICKS) >= CNT_SPAN ||
      FILL_LIMIT < 1 || longint'(FILL_LIMIT) >= CNT_SPAN ||
      DRAIN_LIMIT < 1 || longint'(DRAIN_LIMIT) >= CNT_SPAN) begin : g_bad_param
    $error("wash_ctrl_multi_rinse: tick/limit parameter is 0 or does not fit TMR_W");
  end

  localparam logic [TMR_W-1:0] WASH_LD  = TMR_W'(WASH_TICKS - 1);
  localparam logic [TMR_W-1:0] RINSE_LD = TMR_W'(RINSE_TICKS - 1);
  localparam logic [TMR_W-1:0] SPIN_LD  = TMR_W'(SPIN_TICKS - 1);
  localparam logic [TMR_W-1:0] FILL_WD  = TMR_W'(FILL_LIMIT - 1);
  localparam logic [TMR_W-1:0] DRAIN_WD = TMR_W'(DRAIN_LIMIT - 1);
  localparam logic [RI_W-1:0]  RC       = RI_W'(RINSE_CNT);

  state_e           r_state, w_state_nxt;
  phase_e           r_phase, w_phase_nxt;
  logic [RI_W-1:0]  r_rinse_idx, w_idx_nxt, w_idx_inc;
  logic [TMR_W-1:0] r_wd;
  logic [TMR_W-1:0] w_tmr_val;
  logic             w_tmr_load, w_tmr_zero, w_run, w_door_flt;
  // Sensor/pause samples keep every output a pure function of registers.
  logic             r_pause, r_drained;

  // Timed states advance only when the registered pause is low.
  assign w_run = (r_state == ST_WASH || r_state == ST_SPIN) && !r_pause;

  wash_phase_timer #(.TMR_W(TMR_W)) u_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_hold     (!w_run),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= ST_IDLE;
      r_phase     <= PH_SOAP;
      r_rinse_idx <= '0;
      r_wd        <= '0;
      r_pause     <= 1'b0;
      r_drained   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_rinse_idx <= w_idx_nxt;
      r_pause     <= i_pause;
      r_drained   <= i_drained;
      // Watchdog restarts on every state change, so it counts from FILL/DRAIN entry.
      if (w_state_nxt != r_state) begin
        r_wd <= '0;
      end else if ((r_state == ST_FILL || r_state == ST_DRAIN) && r_wd != '1) begin
        r_wd <= r_wd + TMR_W'(1);
      end
    end
  end

  // A rinse-phase drain completes one rinse pass.
  assign w_idx_inc = r_rinse_idx + ((r_phase == PH_RINSE) ? RI_W'(1) : RI_W'(0));

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_idx_nxt   = r_rinse_idx;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    w_door_flt  = !i_door_close && (r_state inside {ST_FILL, ST_DETERGENT, ST_WASH,
                                                    ST_DRAIN, ST_SPIN});
    if (w_door_flt) begin
      w_state_nxt = ST_FAULT;
    end else begin
      case (r_state)
        ST_IDLE: if (i_start && i_door_close) begin
          w_state_nxt = ST_FILL;
          w_phase_nxt = PH_SOAP;
          w_idx_nxt   = '0;
        end
        ST_FILL: if (i_filled) begin
          if (r_phase == PH_SOAP) begin
            w_state_nxt = ST_DETERGENT;
          end else begin
            w_state_nxt = ST_WASH;
            w_tmr_load  = 1'b1;
            w_tmr_val   = RINSE_LD;
          end
        end else if (r_wd == FILL_WD) begin
          w_state_nxt = ST_FAULT;
        end
        ST_DETERGENT: if (i_detergent_added) begin
          w_state_nxt = ST_WASH;
          w_tmr_load  = 1'b1;
          w_tmr_val   = WASH_LD;
        end
        ST_WASH: if (w_run && w_tmr_zero) w_state_nxt = ST_DRAIN;
        ST_DRAIN: if (i_drained) begin
          w_idx_nxt = w_idx_inc;
          if (w_idx_inc < RC) begin
            w_state_nxt = ST_FILL;
            w_phase_nxt = PH_RINSE;
          end else begin
            w_state_nxt = ST_SPIN;
            w_tmr_load  = 1'b1;
            w_tmr_val   = SPIN_LD;
          end
        end else if (r_wd == DRAIN_WD) begin
          w_state_nxt = ST_FAULT;
        end
        ST_SPIN:  if (w_run && w_tmr_zero) w_state_nxt = ST_DONE;
        ST_DONE:  if (!i_start) w_state_nxt = ST_IDLE;
        ST_FAULT: if (i_drained && !i_start) w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_door_lock      = 1'b0;
    o_motor_on       = 1'b0;
    o_fill_valve_on  = 1'b0;
    o_drain_valve_on = 1'b0;
    o_detergent_req  = 1'b0;
    o_done           = 1'b0;
    o_fault          = 1'b0;
    case (r_state)
      ST_FILL:      begin o_door_lock = 1'b1; o_fill_valve_on = 1'b1; end
      ST_DETERGENT: begin o_door_lock = 1'b1; o_detergent_req = 1'b1; end
      ST_WASH:      begin o_door_lock = 1'b1; o_motor_on = !r_pause; end
      ST_DRAIN:     begin o_door_lock = 1'b1; o_drain_valve_on = 1'b1; end
      ST_SPIN: begin
        o_door_lock      = 1'b1;
        o_motor_on       = !r_pause;
        o_drain_valve_on = !r_pause;
      end
      ST_DONE:      o_done = 1'b1;
      // Keep pumping and keep the door locked until the drum reports empty.
      ST_FAULT: begin
        o_fault          = 1'b1;
        o_drain_valve_on = !r_drained;
        o_door_lock      = !r_drained;
      end
      default: ;
    endcase
  end

  assign o_state     = r_state;
  assign o_rinse_idx = r_rinse_idx;

endmodule
